// File: rtl/seg_readback.sv
// seg_readback: decodes a multiplexed common-anode 7-segment bus
// back into digit codes and publishes one frame per full scan.
module seg_readback #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_DIGITS-1:0]   an_n,
   input  logic [6:0]              seg,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic                    frame_valid,
   output logic [7:0]              frame_cnt
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

   typedef enum logic [1:0] {IDLE, DWELL, HELD} state_t;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic [CW-1:0]           cnt_nx;
   logic [NUM_DIGITS-1:0]   s_an;
   logic [6:0]              s_seg;
   logic [NUM_DIGITS-1:0]   mask;
   logic [NUM_DIGITS-1:0]   mask_nx;
   logic [4*NUM_DIGITS-1:0] slot_d;
   logic [NUM_DIGITS-1:0]   slot_e;
   logic [3:0]              zeros;
   logic [IW-1:0]           idx;
   logic                    in_valid;
   logic                    same;
   logic                    capture;
   logic                    full;
   logic [3:0]              code;
   logic                    bad;

   // Locate the single active anode and qualify the bus
   always_comb begin
      zeros = '0;
      idx   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!an_n[i]) begin
            zeros = zeros + 4'd1;
            idx   = IW'(i);
         end
      end
      in_valid = (zeros == 4'd1);
      same     = (an_n == s_an) && (seg == s_seg);
   end

   // Next dwell count: restart on change, saturate when held
   always_comb begin
      cnt_nx = '0;
      if (in_valid) begin
         if (!same)
            cnt_nx = CW'(1);
         else if (cnt == CMAX)
            cnt_nx = cnt;
         else
            cnt_nx = cnt + 1'b1;
      end
   end

   // Glyph to digit code; unknown patterns flag an error
   always_comb begin
      bad  = 1'b0;
      code = 4'hE;
      unique case (seg)
         7'b1000000: code = 4'h0;
         7'b1111001: code = 4'h1;
         7'b0100100: code = 4'h2;
         7'b0110000: code = 4'h3;
         7'b0011001: code = 4'h4;
         7'b0010010: code = 4'h5;
         7'b0000010: code = 4'h6;
         7'b1111000: code = 4'h7;
         7'b0000000: code = 4'h8;
         7'b0010000: code = 4'h9;
         7'b1111111: code = 4'hF;
         default:    bad  = 1'b1;
      endcase
   end

   // Capture only on the edge the dwell completes; publish clears first
   always_comb begin
      full    = &mask;
      capture = (state != HELD) && (cnt_nx == CMAX);
      mask_nx = full ? '0 : mask;
      if (capture)
         mask_nx[idx] = 1'b1;
   end

   // Dwell tracker: sample registers, counter and state
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         s_an  <= '1;
         s_seg <= '1;
      end else begin
         s_an  <= an_n;
         s_seg <= seg;
         cnt   <= cnt_nx;
         unique case (1'b1)
            (cnt_nx == '0):  state <= IDLE;
            (cnt_nx == CMAX): state <= HELD;
            default:         state <= DWELL;
         endcase
      end
   end

   // Slot capture and frame publication
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_d      <= '0;
         slot_e      <= '0;
         mask        <= '0;
         digits_out  <= '0;
         digit_err   <= '0;
         frame_valid <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         mask        <= mask_nx;
         frame_valid <= full;
         if (full) begin
            digits_out <= slot_d;
            digit_err  <= slot_e;
            frame_cnt  <= frame_cnt + 8'd1;
         end
         if (capture) begin
            slot_d[{idx, 2'b00} +: 4] <= code;
            slot_e[idx]               <= bad;
         end
      end
   end

endmodule
